// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford result unload path.
package bf_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8192;
  localparam logic [15:0] INF_CODE = 16'hFFFF;

  // Streamer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    NEG    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bf_result_streamer.sv
// Unloads the Output Memory onto a valid/ready stream once the solver
// finishes, or emits a single flagged word if a negative cycle was found.
module bf_result_streamer #(
  parameter int ADDR_W = bf_pkg::ADDR_W,
  parameter int DATA_W = bf_pkg::DATA_W,
  parameter int DEPTH  = bf_pkg::DEPTH,
  parameter logic [DATA_W-1:0] INF_CODE = bf_pkg::INF_CODE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutInf,
  output logic              OutNeg,
  output logic              OutLast,
  output logic [ADDR_W:0]   InfCount,
  output logic              Busy,
  output logic              Done
);

  import bf_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state, nextState;

  logic [ADDR_W-1:0] addr;
  logic              issuedAll;
  logic              prevFinish;
  logic              prevNeg;

  logic finishEdge;
  logic negEdge;
  logic accept;
  logic load;

  assign finishEdge = Finish & ~prevFinish;
  assign negEdge    = NegCycle & ~prevNeg;
  assign accept     = OutValid & OutReady;
  assign load       = (state == STREAM) & (~OutValid | OutReady) & ~issuedAll;

  assign OMAR = addr;
  assign Busy = (state == STREAM) || (state == NEG);
  assign Done = (state == DONE);

  // Remember last cycle's solver flags so only rising edges start a run
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prevFinish <= 1'b0;
      prevNeg    <= 1'b0;
    end else begin
      prevFinish <= Finish;
      prevNeg    <= NegCycle;
    end
  end

  // Control state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic; negative cycle wins over a simultaneous finish
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (negEdge)         nextState = NEG;
        else if (finishEdge) nextState = STREAM;
      end
      STREAM: begin
        if (accept && OutLast) nextState = DONE;
      end
      NEG: begin
        if (accept) nextState = DONE;
      end
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // Output register, read address counter and INF tally; outputs hold while stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      issuedAll <= 1'b0;
      OutValid  <= 1'b0;
      OutData   <= '0;
      OutIndex  <= '0;
      OutInf    <= 1'b0;
      OutNeg    <= 1'b0;
      OutLast   <= 1'b0;
      InfCount  <= '0;
    end else begin
      if (accept && OutInf) InfCount <= InfCount + 1'b1;

      case (state)
        STREAM: begin
          if (load) begin
            OutData  <= OMDR;
            OutIndex <= addr;
            OutInf   <= (OMDR == INF_CODE);
            OutLast  <= (addr == LAST_ADDR);
            OutValid <= 1'b1;
            if (addr == LAST_ADDR) issuedAll <= 1'b1;
            else                   addr      <= addr + 1'b1;
          end else if (accept) begin
            OutValid <= 1'b0;
          end
        end
        NEG: begin
          if (!OutValid) begin
            OutData  <= '0;
            OutIndex <= '0;
            OutInf   <= 1'b0;
            OutNeg   <= 1'b1;
            OutLast  <= 1'b1;
            OutValid <= 1'b1;
          end else if (accept) begin
            OutValid <= 1'b0;
          end
        end
        default: begin
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_result_streamer.sv
// Directed bench for bf_result_streamer with an 8-word Output Memory.
module tb_bf_result_streamer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam logic [15:0] INF = 16'hFFFF;

  logic              clock;
  logic              reset;
  logic              Finish;
  logic              NegCycle;
  logic [ADDR_W-1:0] OMAR;
  logic [DATA_W-1:0] OMDR;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIndex;
  logic              OutInf;
  logic              OutNeg;
  logic              OutLast;
  logic [ADDR_W:0]   InfCount;
  logic              Busy;
  logic              Done;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  int testCount = 0;
  int failCount = 0;

  bf_result_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .INF_CODE(INF)
  ) dut (
    .clock(clock), .reset(reset), .Finish(Finish), .NegCycle(NegCycle),
    .OMAR(OMAR), .OMDR(OMDR), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutIndex(OutIndex), .OutInf(OutInf), .OutNeg(OutNeg),
    .OutLast(OutLast), .InfCount(InfCount), .Busy(Busy), .Done(Done)
  );

  // Combinational read port of the memory model
  assign OMDR = mem[OMAR[2:0]];

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the solver status flags
  task automatic applyStimulus(input logic fin, input logic neg);
    Finish   = fin;
    NegCycle = neg;
  endtask

  // Hold reset across two edges with all inputs idle
  task automatic doReset();
    reset    = 1'b1;
    OutReady = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Raise Finish and confirm the two-edge start latency
  task automatic startFinish();
    OutReady = 1'b1;
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("lat_edge1_valid", OutValid, 0);
    checkOutput("lat_edge1_busy", Busy, 1);
    tick();
    checkOutput("lat_edge2_valid", OutValid, 1);
    checkOutput("lat_edge2_index", OutIndex, 0);
  endtask

  // Consume a whole run, checking order, content, stalls and completion
  task automatic runStream(input bit randomReady, input int expInf);
    int expIdx, cycles, infSeen;
    bit stalled;
    logic [63:0] held, snap;
    expIdx = 0; cycles = 0; infSeen = 0; stalled = 0; held = '0;
    while (expIdx < DEPTH && cycles < 400) begin
      snap = {19'b0, OutData, OutIndex, OutInf, OutNeg, OutLast, OMAR};
      if (stalled) checkOutput("stall_hold", snap, held);
      OutReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (OutValid && OutReady) begin
        checkOutput("word_index", OutIndex, expIdx);
        checkOutput("word_data", OutData, mem[expIdx]);
        checkOutput("word_inf", OutInf, (mem[expIdx] == INF));
        checkOutput("word_last", OutLast, (expIdx == DEPTH - 1));
        checkOutput("word_neg", OutNeg, 0);
        checkOutput("word_infcount", InfCount, infSeen);
        if (mem[expIdx] == INF) infSeen++;
        expIdx++;
      end
      stalled = OutValid && !OutReady;
      held = snap;
      tick();
      cycles++;
    end
    checkOutput("run_complete", expIdx, DEPTH);
    if (!randomReady) checkOutput("run_cycles", cycles, DEPTH);
    checkOutput("end_done", Done, 1);
    checkOutput("end_busy", Busy, 0);
    checkOutput("end_valid", OutValid, 0);
    checkOutput("end_infcount", InfCount, expInf);
  endtask

  // Neg-cycle word presentation, a short stall, then acceptance
  task automatic checkNegWord();
    OutReady = 1'b0;
    tick();
    checkOutput("neg_edge1_valid", OutValid, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("neg_valid", OutValid, 1);
      checkOutput("neg_flag", OutNeg, 1);
      checkOutput("neg_last", OutLast, 1);
      checkOutput("neg_data", OutData, 0);
      checkOutput("neg_index", OutIndex, 0);
      checkOutput("neg_omar", OMAR, 0);
      if (k == 2) OutReady = 1'b1;
      tick();
    end
    checkOutput("neg_done", Done, 1);
    checkOutput("neg_after_valid", OutValid, 0);
    checkOutput("neg_after_omar", OMAR, 0);
    checkOutput("neg_infcount", InfCount, 0);
  endtask

  initial begin
    reset = 1'b1;
    OutReady = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);

    // Reset state
    doReset();
    checkOutput("rst_valid", OutValid, 0);
    checkOutput("rst_omar", OMAR, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_infcount", InfCount, 0);

    // Full-rate stream of Mem[i]=i
    startFinish();
    runStream(1'b0, 0);

    // Two unreachable vertices
    mem[3] = INF;
    mem[5] = INF;
    doReset();
    startFinish();
    runStream(1'b0, 2);

    // Random back-pressure
    doReset();
    startFinish();
    runStream(1'b1, 2);

    // Negative cycle alone
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 100);
    doReset();
    applyStimulus(1'b0, 1'b1);
    checkNegWord();

    // Both flags together, then a late Finish pulse that must be ignored
    doReset();
    applyStimulus(1'b1, 1'b1);
    checkNegWord();
    applyStimulus(1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("done_ignore_valid", OutValid, 0);
      checkOutput("done_ignore_done", Done, 1);
    end

    // Reset mid-run, then restart from index 0
    doReset();
    startFinish();
    begin
      int guard;
      guard = 0;
      while (!(OutValid && OutIndex == 4) && guard < 20) begin
        tick();
        guard++;
      end
      checkOutput("midrun_reached_idx4", OutIndex, 4);
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("midrun_rst_valid", OutValid, 0);
    checkOutput("midrun_rst_omar", OMAR, 0);
    checkOutput("midrun_rst_busy", Busy, 0);
    #2 reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    startFinish();
    runStream(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
